// File: rtl/fetch_stage.sv
// fetch_stage: PC register plus IF/ID pipeline register with stall, flush, redirect and a delivered-instruction counter
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD,
  output logic [31:0] FetchCount
);
  logic [29:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc8;
  logic        r_valid;
  logic [31:0] r_cnt;
  logic        w_load;
  assign w_load     = !FlushD && !StallD;
  assign PCF        = {r_pc, 2'b00};
  assign InstrD     = r_instr;
  assign PCPlus8D   = r_pc8;
  assign ValidD     = r_valid;
  assign FetchCount = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC[31:2];
      r_instr <= NOP_INSTR;
      r_pc8   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (BranchTakenE) r_pc <= BranchTargetE[31:2];
      else if (!StallF) r_pc <= r_pc + 30'd1;
      if (FlushD) begin
        r_instr <= NOP_INSTR;
        r_pc8   <= '0;
        r_valid <= 1'b0;
      end else if (!StallD) begin
        r_instr <= InstrF;
        r_pc8   <= {r_pc + 30'd2, 2'b00};
        r_valid <= 1'b1;
      end
      if (w_load) r_cnt <= r_cnt + 32'd1;
    end
  end
endmodule
